pair_sum_stage: RTL and testbench

PAIR_SUM_STAGE -- requirements
Module: pair_sum_stage

---
 rtl/pair_sum_stage_pkg.sv | 39 +++
 rtl/pair_skid_buf.sv | 101 ++++++++++
 rtl/pair_sum_stage.sv | 94 +++++++++
 tb/tb_pair_sum_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pair_sum_stage_pkg.sv
// Shared widths, bin_data field layout and entry types for the pair-sum path.
// The file readers and the APB master use the same definitions.
package pair_sum_stage_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int SUM_W  = 17;
    localparam int PSEL_W = 2;
    localparam int BIN_W  = ADDR_W + DATA_W + PSEL_W;

    // bin_data layout: addr[21:18], data[17:2], psel[1:0]
    localparam int BIN_PSEL_LSB = 0;
    localparam int BIN_DATA_LSB = BIN_PSEL_LSB + PSEL_W;
    localparam int BIN_ADDR_LSB = BIN_DATA_LSB + DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SUM_W-1:0]  sum;
        logic [PSEL_W-1:0] psel;
    } pair_entry_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

    // Build one buffer entry from a binary word and a decimal word.
    // Both operands are zero-extended so the carry lands in sum[16].
    function automatic pair_entry_t make_entry(input logic [BIN_W-1:0]  bin,
                                               input logic [DATA_W-1:0] dec);
        pair_entry_t e;
        e.addr = bin[BIN_ADDR_LSB +: ADDR_W];
        e.sum  = {1'b0, bin[BIN_DATA_LSB +: DATA_W]} + {1'b0, dec};
        e.psel = bin[BIN_PSEL_LSB +: PSEL_W];
        return e;
    endfunction

endpackage

// File: rtl/pair_skid_buf.sv
// Two-entry in-order buffer with valid/ready on both sides.
// The head entry is always held in a register, so the output side is glitch-free
// and stays stable while the consumer stalls.
module pair_skid_buf
    import pair_sum_stage_pkg::*;
(
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_s_valid,
    output logic        o_s_ready,
    input  pair_entry_t i_s_entry,
    output logic        o_m_valid,
    input  logic        i_m_ready,
    output pair_entry_t o_m_entry,
    output logic [1:0]  o_occ
);

    occ_state_t  r_state;
    occ_state_t  w_next;
    pair_entry_t r_head;
    pair_entry_t r_tail;
    logic        w_push;
    logic        w_pop;
    logic        w_head_from_in;
    logic        w_head_from_tail;
    logic        w_tail_from_in;

    // A full buffer can still accept when the head leaves in the same cycle.
    assign o_s_ready = (r_state != OCC_TWO) || i_m_ready;
    assign o_m_valid = (r_state != OCC_EMPTY);
    assign o_m_entry = r_head;
    assign o_occ     = r_state;

    assign w_push = i_s_valid && o_s_ready;
    assign w_pop  = o_m_valid && i_m_ready;

    // Occupancy state register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= OCC_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    // Next occupancy and which storage slots load this cycle.
    always_comb begin
        w_next           = r_state;
        w_head_from_in   = 1'b0;
        w_head_from_tail = 1'b0;
        w_tail_from_in   = 1'b0;
        case (r_state)
            OCC_EMPTY: begin
                if (w_push) begin
                    w_next         = OCC_ONE;
                    w_head_from_in = 1'b1;
                end
            end
            OCC_ONE: begin
                case ({w_push, w_pop})
                    2'b11: w_head_from_in = 1'b1;
                    2'b10: begin
                        w_next         = OCC_TWO;
                        w_tail_from_in = 1'b1;
                    end
                    2'b01: w_next = OCC_EMPTY;
                    default: w_next = OCC_ONE;
                endcase
            end
            OCC_TWO: begin
                if (w_pop) begin
                    w_head_from_tail = 1'b1;
                    if (w_push) begin
                        w_tail_from_in = 1'b1;
                    end else begin
                        w_next = OCC_ONE;
                    end
                end
            end
            default: w_next = OCC_EMPTY;
        endcase
    end

    // Entry storage; cleared on reset so the presented fields read zero.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_head_from_in) begin
                r_head <= i_s_entry;
            end else if (w_head_from_tail) begin
                r_head <= r_tail;
            end
            if (w_tail_from_in) begin
                r_tail <= i_s_entry;
            end
        end
    end

endmodule

// File: rtl/pair_sum_stage.sv
// Pops one word from each of the binary and decimal FIFOs together, adds the
// data fields, and presents {addr, sum, psel} to the APB master through a
// two-entry buffer. Pops are throttled so the buffer can never overflow.
module pair_sum_stage
    import pair_sum_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BIN_W-1:0]  bin_data,
    input  logic              bin_empty,
    output logic              bin_rd_en,
    input  logic [DATA_W-1:0] dec_data,
    input  logic              dec_empty,
    output logic              dec_rd_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [SUM_W-1:0]  m_wdata,
    output logic [PSEL_W-1:0] m_psel,
    output logic [15:0]       pair_count
);

    logic        r_armed;
    logic        r_inflight;
    logic [15:0] r_pair_count;
    logic [1:0]  w_occ;
    logic [2:0]  w_level;
    logic        w_xfer;
    logic        w_room;
    logic        w_pop;
    logic        w_s_ready;
    logic        w_capture;
    pair_entry_t w_in_entry;
    pair_entry_t w_head;

    // Entries already owned (buffered or in flight) minus the one leaving now
    // must leave space for the word this pop will deliver next cycle.
    assign w_level = {1'b0, w_occ} + {2'b00, r_inflight};
    assign w_room  = (w_level - {2'b00, w_xfer}) < 3'd2;
    assign w_pop   = r_armed && !bin_empty && !dec_empty && w_room;

    assign bin_rd_en = w_pop;
    assign dec_rd_en = w_pop;

    // FIFO read data is valid the cycle after the pop strobe.
    assign w_in_entry = make_entry(bin_data, dec_data);
    assign w_capture  = r_inflight && w_s_ready;

    assign w_xfer     = m_valid && m_ready;
    assign m_addr     = w_head.addr;
    assign m_wdata    = w_head.sum;
    assign m_psel     = w_head.psel;
    assign pair_count = r_pair_count;

    // Hold off popping for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
        end
    end

    // Remember that read data arrives next cycle; reset discards it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_pop;
        end
    end

    // Count entries handed to the master, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pair_count <= 16'd0;
        end else if (w_xfer) begin
            r_pair_count <= r_pair_count + 16'd1;
        end
    end

    pair_skid_buf u_buf (
        .clk       (clk),
        .i_rst_n   (rst),
        .i_s_valid (w_capture),
        .o_s_ready (w_s_ready),
        .i_s_entry (w_in_entry),
        .o_m_valid (m_valid),
        .i_m_ready (m_ready),
        .o_m_entry (w_head),
        .o_occ     (w_occ)
    );

endmodule

// File: tb/tb_pair_sum_stage.sv
// Bench for pair_sum_stage: FIFO models, scoreboard queue and monitor.
module tb_pair_sum_stage;

    logic        clk;
    logic        rst;
    logic [21:0] bin_data;
    logic        bin_empty;
    logic        bin_rd_en;
    logic [15:0] dec_data;
    logic        dec_empty;
    logic        dec_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_addr;
    logic [16:0] m_wdata;
    logic [1:0]  m_psel;
    logic [15:0] pair_count;

    int tests = 0;
    int fails = 0;
    int rd_cnt = 0;

    logic [22:0] exp_q[$];
    logic [21:0] binq[$];
    logic [15:0] decq[$];
    logic        pop_pend = 1'b0;
    logic        dec_hold = 1'b0;
    logic        prev_stall = 1'b0;
    logic [22:0] prev_word = '0;

    pair_sum_stage dut (
        .clk        (clk),
        .rst        (rst),
        .bin_data   (bin_data),
        .bin_empty  (bin_empty),
        .bin_rd_en  (bin_rd_en),
        .dec_data   (dec_data),
        .dec_empty  (dec_empty),
        .dec_rd_en  (dec_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_psel     (m_psel),
        .pair_count (pair_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_pair(input logic [3:0] a, input logic [15:0] d, input logic [1:0] p,
                             input logic [15:0] dv, input logic [16:0] s);
        binq.push_back({a, d, p});
        decq.push_back(dv);
        exp_q.push_back({a, s, p});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_valid && !bin_rd_en) break;
        end
        check({"drain_", name}, exp_q.size(), 0);
    endtask

    // FIFO models: a pop strobed in cycle N shows its word in cycle N+1.
    initial begin
        bin_data  = '0;
        dec_data  = '0;
        bin_empty = 1'b1;
        dec_empty = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (pop_pend) begin
                if (binq.size() > 0) bin_data = binq.pop_front();
                if (decq.size() > 0) dec_data = decq.pop_front();
                pop_pend = 1'b0;
            end
            bin_empty = (binq.size() == 0);
            dec_empty = (decq.size() == 0) || dec_hold;
        end
    end

    // Monitor: pop counting, stall stability and scoreboard comparison.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bin_rd_en || dec_rd_en) check("rd_en_pair", dec_rd_en, bin_rd_en);
                pop_pend = bin_rd_en;
                if (bin_rd_en) rd_cnt++;
                if (prev_stall) begin
                    check("stall_valid", m_valid, 1);
                    check("stall_data", {m_addr, m_wdata, m_psel}, prev_word);
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_xfer: got 0x%0h, expected no transfer",
                                 {m_addr, m_wdata, m_psel});
                    end else begin
                        logic [22:0] e;
                        e = exp_q.pop_front();
                        check("xfer_addr", m_addr, e[22:19]);
                        check("xfer_wdata", m_wdata, e[18:2]);
                        check("xfer_psel", m_psel, e[1:0]);
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_word  = {m_addr, m_wdata, m_psel};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        logic found;
        logic mv_seen;
        int   cur_rd, max_rd, cur_mv, max_mv;

        rst     = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_bin_rd_en", bin_rd_en, 0);
        check("rst_dec_rd_en", dec_rd_en, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_m_psel", m_psel, 0);
        check("rst_pair_count", pair_count, 0);

        // Single pair, already waiting when reset releases
        push_pair(4'h2, 16'h048D, 2'h1, 16'h0005, 17'h00492);
        @(posedge clk); #1;
        rst     = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        check("no_pop_first_cycle", bin_rd_en, 0);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clk);
            if (bin_rd_en) found = 1'b1;
        end
        check("single_pop_seen", found, 1);
        @(negedge clk);
        check("single_rd_once", bin_rd_en, 0);
        check("single_lat1_valid", m_valid, 0);
        @(negedge clk);
        check("single_lat2_valid", m_valid, 1);
        check("single_addr", m_addr, 4'h2);
        check("single_wdata", m_wdata, 17'h00492);
        check("single_psel", m_psel, 2'h1);
        @(negedge clk);
        check("single_valid_drop", m_valid, 0);
        check("single_count", pair_count, 1);

        // Carry into bit 16
        @(posedge clk); #1;
        push_pair(4'h7, 16'hFFFF, 2'h3, 16'h0001, 17'h10000);
        drain("carry");
        check("carry_count", pair_count, 2);

        // Backpressure: four pairs queued, master stalled
        @(posedge clk); #1;
        m_ready = 1'b0;
        rd_cnt  = 0;
        push_pair(4'h1, 16'h0001, 2'h0, 16'h0002, 17'h00003);
        push_pair(4'h2, 16'h1000, 2'h1, 16'h0100, 17'h01100);
        push_pair(4'h3, 16'h8000, 2'h2, 16'h8000, 17'h10000);
        push_pair(4'h4, 16'hABCD, 2'h3, 16'h1111, 17'h0BCDE);
        repeat (10) @(posedge clk);
        #1;
        check("bp_two_pops", rd_cnt, 2);
        check("bp_valid_held", m_valid, 1);
        check("bp_head_addr", m_addr, 4'h1);
        check("bp_head_wdata", m_wdata, 17'h00003);
        m_ready = 1'b1;
        drain("backpressure");
        check("bp_total_pops", rd_cnt, 4);
        check("bp_count", pair_count, 6);

        // Empty interlock on the decimal side
        @(posedge clk); #1;
        dec_hold = 1'b1;
        rd_cnt   = 0;
        push_pair(4'h5, 16'h0050, 2'h2, 16'h0007, 17'h00057);
        repeat (10) @(posedge clk);
        #1;
        check("interlock_no_pop", rd_cnt, 0);
        dec_hold = 1'b0;
        @(negedge clk);
        check("interlock_pop_next", bin_rd_en, 1);
        drain("interlock");
        check("interlock_count", pair_count, 7);

        // Streaming eight pairs with the master always ready
        @(posedge clk); #1;
        push_pair(4'h0, 16'h0000, 2'h0, 16'h0000, 17'h00000);
        push_pair(4'h1, 16'h0011, 2'h1, 16'h0022, 17'h00033);
        push_pair(4'h2, 16'h0100, 2'h2, 16'h0200, 17'h00300);
        push_pair(4'h3, 16'h7FFF, 2'h3, 16'h0001, 17'h08000);
        push_pair(4'h4, 16'hFFFE, 2'h0, 16'h0003, 17'h10001);
        push_pair(4'h5, 16'h1234, 2'h1, 16'h4321, 17'h05555);
        push_pair(4'h6, 16'hF000, 2'h2, 16'h1000, 17'h10000);
        push_pair(4'h7, 16'h00FF, 2'h3, 16'hFF01, 17'h10000);
        cur_rd = 0; max_rd = 0; cur_mv = 0; max_mv = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cur_rd = bin_rd_en ? cur_rd + 1 : 0;
            cur_mv = m_valid ? cur_mv + 1 : 0;
            if (cur_rd > max_rd) max_rd = cur_rd;
            if (cur_mv > max_mv) max_mv = cur_mv;
        end
        check("stream_rd_run", max_rd, 8);
        check("stream_valid_run", max_mv, 8);
        check("stream_count", pair_count, 15);
        drain("stream");

        // Reset the cycle after a pop
        @(posedge clk); #1;
        push_pair(4'h9, 16'h0001, 2'h1, 16'h0001, 17'h00002);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            @(negedge clk);
            if (bin_rd_en) found = 1'b1;
        end
        check("midrst_pop_seen", found, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst_bin_rd_en", bin_rd_en, 0);
        check("midrst_dec_rd_en", dec_rd_en, 0);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_m_addr", m_addr, 0);
        check("midrst_m_wdata", m_wdata, 0);
        check("midrst_m_psel", m_psel, 0);
        check("midrst_pair_count", pair_count, 0);
        #2;
        exp_q.delete();
        binq.delete();
        decq.delete();
        @(posedge clk); #1;
        rst    = 1'b1;
        rd_cnt = 0;
        mv_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m_valid) mv_seen = 1'b1;
        end
        check("midrst_no_replay", mv_seen, 0);
        @(posedge clk); #1;
        check("midrst_no_pop", rd_cnt, 0);
        push_pair(4'hA, 16'h2222, 2'h2, 16'h1111, 17'h03333);
        drain("after_reset");
        check("after_reset_count", pair_count, 1);

        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
